// File: rtl/hidden_layer_accum_if.sv
// rtl/hidden_layer_accum_if.sv - result handshake between the hidden-layer accumulator and its store
interface hidden_layer_accum_if #(
    parameter int OUT_WIDTH = 8
) ();
    logic                 hid_valid;
    logic                 hid_ready;
    logic [4:0]           hid_idx;
    logic [OUT_WIDTH-1:0] hid_val;

    modport master (output hid_valid, output hid_idx, output hid_val, input hid_ready);
    modport slave  (input hid_valid, input hid_idx, input hid_val, output hid_ready);
endinterface

// File: rtl/hidden_layer_accum.sv
// rtl/hidden_layer_accum.sv - per-neuron weighted sum of set input pixels, ReLU and saturation
module hidden_layer_accum #(
    parameter int NUM_INPUTS = 784,
    parameter int NUM_HIDDEN = 32,
    parameter int W_WIDTH    = 8,
    parameter int ACC_WIDTH  = 18,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic [9:0]                in_addr,
    input  logic                      in_q,
    output logic [14:0]               wt_addr,
    input  logic signed [W_WIDTH-1:0] wt_q,
    hidden_layer_accum_if.master      hid,
    output logic                      busy,
    output logic                      done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DRAIN,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [9:0]  LAST_INDEX  = 10'(NUM_INPUTS - 1);
    localparam logic [4:0]  LAST_NEURON = 5'(NUM_HIDDEN - 1);
    localparam logic [14:0] BASE_STEP   = 15'(NUM_INPUTS);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((1 << OUT_WIDTH) - 1);

    state_t                       state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic [4:0]                   neuron_q;
    logic [9:0]                   index_q;
    logic [14:0]                  base_q;
    logic signed [ACC_WIDTH-1:0]  wt_ext;
    logic [OUT_WIDTH-1:0]         sat_val;

    assign wt_ext = {{(ACC_WIDTH - W_WIDTH){wt_q[W_WIDTH-1]}}, wt_q};

    always_comb begin
        if (acc_q[ACC_WIDTH-1]) begin
            sat_val = '0;
        end else if (acc_q > OUT_MAX) begin
            sat_val = '1;
        end else begin
            sat_val = acc_q[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        in_addr       = '0;
        wt_addr       = '0;
        busy          = 1'b0;
        done          = 1'b0;
        hid.hid_valid = 1'b0;
        hid.hid_idx   = '0;
        hid.hid_val   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ADDR;
            end
            S_ADDR: begin
                busy    = 1'b1;
                in_addr = index_q;
                wt_addr = base_q + {5'd0, index_q};
                if (index_q == LAST_INDEX) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy    = 1'b1;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                busy          = 1'b1;
                hid.hid_valid = 1'b1;
                hid.hid_idx   = neuron_q;
                hid.hid_val   = sat_val;
                if (hid.hid_ready) begin
                    state_d = (neuron_q == LAST_NEURON) ? S_DONE : S_ADDR;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // RAM data lags the address by one cycle, so the first ADDR cycle has nothing to add
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            neuron_q <= '0;
            index_q  <= '0;
            base_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q    <= '0;
                        neuron_q <= '0;
                        index_q  <= '0;
                        base_q   <= '0;
                    end
                end
                S_ADDR: begin
                    if (index_q != '0 && in_q) acc_q <= acc_q + wt_ext;
                    if (index_q != LAST_INDEX) index_q <= index_q + 10'd1;
                end
                S_DRAIN: begin
                    if (in_q) acc_q <= acc_q + wt_ext;
                end
                S_EMIT: begin
                    if (hid.hid_ready && neuron_q != LAST_NEURON) begin
                        neuron_q <= neuron_q + 5'd1;
                        base_q   <= base_q + BASE_STEP;
                        index_q  <= '0;
                        acc_q    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hidden_layer_accum.sv
// tb/tb_hidden_layer_accum.sv - self-checking bench for hidden_layer_accum
module tb_hidden_layer_accum;
    localparam int NI = 784;
    localparam int NH = 32;

    logic        clk = 1'b0;
    logic        rst_n, start, in_q;
    logic [9:0]  in_addr;
    logic [14:0] wt_addr;
    logic [7:0]  wt_q;
    logic        busy, done;

    hidden_layer_accum_if #(.OUT_WIDTH(8)) hif ();

    hidden_layer_accum dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in_addr (in_addr),
        .in_q    (in_q),
        .wt_addr (wt_addr),
        .wt_q    (wt_q),
        .hid     (hif),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    logic       pix  [0:1023];
    logic [7:0] wmem [0:32767];

    always @(posedge clk) begin
        in_q <= pix[in_addr];
        wt_q <= wmem[wt_addr];
    end

    int checks = 0;
    int failures = 0;
    int exp_val [0:NH-1];
    int got     [0:NH-1];
    bit full_lat = 0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic setw(input int n, input int i, input int v);
        wmem[n*NI + i] = 8'(v);
    endtask

    task automatic compute_expected();
        for (int n = 0; n < NH; n++) begin
            int sum = 0;
            for (int i = 0; i < NI; i++)
                if (pix[i]) sum += int'($signed(wmem[n*NI + i]));
            exp_val[n] = (sum < 0) ? 0 : (sum > 255) ? 255 : sum;
        end
    endtask

    // kind 0: wt_addr reaches arg, 1: hid_valid, 2: done
    task automatic wait_for(input int kind, input int arg, input int limit, input string name);
        bit found = 0;
        int n = 0;
        while (!found && n < limit) begin
            @(posedge clk);
            #1;
            n++;
            case (kind)
                0: found = (int'(wt_addr) == arg);
                1: found = hif.hid_valid;
                default: found = done;
            endcase
        end
        if (!found) chk(1'b0, name, n, limit);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk(in_addr == 0, {tag, "_in_addr"}, int'(in_addr), 0);
        chk(wt_addr == 0, {tag, "_wt_addr"}, int'(wt_addr), 0);
        chk(hif.hid_valid == 0, {tag, "_hid_valid"}, int'(hif.hid_valid), 0);
        chk(hif.hid_idx == 0, {tag, "_hid_idx"}, int'(hif.hid_idx), 0);
        chk(hif.hid_val == 0, {tag, "_hid_val"}, int'(hif.hid_val), 0);
        chk(busy == 0, {tag, "_busy"}, int'(busy), 0);
        chk(done == 0, {tag, "_done"}, int'(done), 0);
    endtask

    task automatic check_literals();
        chk(got[0] == 255, "n0_saturate", got[0], 255);
        chk(got[1] == 0, "n1_relu", got[1], 0);
        chk(got[2] == 30, "n2_pix0to9_w3", got[2], 30);
        chk(got[3] == 30, "n3_mixed", got[3], 30);
        chk(got[5] == 100, "n5_pix783", got[5], 100);
        chk(got[6] == 255, "n6_max_pos", got[6], 255);
        chk(got[7] == 0, "n7_max_neg", got[7], 0);
        chk(got[8] == 255, "n8_exact255", got[8], 255);
        chk(got[9] == 255, "n9_256", got[9], 255);
        chk(got[10] == 0, "n10_minus1", got[10], 0);
        chk(got[11] == 0, "n11_zero", got[11], 0);
        chk(got[13] == 254, "n13_254", got[13], 254);
    endtask

    // Cycle-level expectation of one layer: 784 address cycles, one drain cycle, then the held result
    initial begin
        bit active = 0;
        bit expect_done = 0;
        int ptr = 0;
        int pos = 0;
        int cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0;
                expect_done = 0;
            end else if (expect_done) begin
                cyc++;
                chk(done == 1, "done_pulse", int'(done), 1);
                chk(busy == 0, "busy_at_done", int'(busy), 0);
                if (full_lat) chk(cyc == 25152, "layer_latency", cyc, 25152);
                expect_done = 0;
                active = 0;
            end else if (active) begin
                cyc++;
                chk(busy == 1, "busy_active", int'(busy), 1);
                if (pos < NI) begin
                    chk(int'(in_addr) == pos, "in_addr_seq", int'(in_addr), pos);
                    chk(int'(wt_addr) == ptr*NI + pos, "wt_addr_seq", int'(wt_addr), ptr*NI + pos);
                    chk(hif.hid_valid == 0, "valid_in_addr", int'(hif.hid_valid), 0);
                    if (ptr == NH-1 && pos == NI-1)
                        chk(wt_addr == 15'd25087, "last_wt_addr", int'(wt_addr), 25087);
                    pos++;
                end else if (pos == NI) begin
                    chk(in_addr == 0 && wt_addr == 0, "drain_addr", int'(wt_addr), 0);
                    chk(hif.hid_valid == 0, "valid_in_drain", int'(hif.hid_valid), 0);
                    pos++;
                end else begin
                    chk(hif.hid_valid == 1, "hid_valid", int'(hif.hid_valid), 1);
                    chk(int'(hif.hid_idx) == ptr, "hid_idx", int'(hif.hid_idx), ptr);
                    chk(int'(hif.hid_val) == exp_val[ptr], "hid_val", int'(hif.hid_val), exp_val[ptr]);
                    chk(in_addr == 0 && wt_addr == 0, "emit_addr", int'(wt_addr), 0);
                    if (hif.hid_ready) begin
                        got[ptr] = int'(hif.hid_val);
                        ptr++;
                        pos = 0;
                        if (ptr == NH) expect_done = 1;
                    end
                end
            end else begin
                chk(busy == 0 && hif.hid_valid == 0 && done == 0 && in_addr == 0 && wt_addr == 0,
                    "idle_outputs", int'({busy, hif.hid_valid, done}), 0);
                if (start) begin
                    active = 1;
                    ptr = 0;
                    pos = 0;
                    cyc = -1;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        hif.hid_ready = 1'b1;

        for (int i = 0; i < 1024; i++) pix[i] = (i < 10) || (i >= 400 && i < 700) || (i == 783);
        for (int a = 0; a < 32768; a++) wmem[a] = 8'd0;
        for (int i = 0; i < NI; i++) begin
            setw(0, i, 1);
            setw(1, i, -1);
            setw(6, i, 127);
            setw(7, i, -128);
        end
        for (int i = 0; i < 10; i++) begin
            setw(2, i, 3);
            setw(3, i, -1);
            setw(8, i, 25);
            setw(9, i, 25);
            setw(13, i, 25);
        end
        setw(3, 783, 40);
        setw(5, 783, 100);
        setw(8, 783, 5);
        setw(9, 783, 6);
        setw(13, 783, 4);
        setw(10, 0, -1);
        setw(11, 0, 5);
        setw(11, 1, -5);
        for (int n = 14; n < NH; n++)
            for (int i = 0; i < NI; i++) setw(n, i, int'($urandom_range(0, 255)));
        for (int i = 0; i < NI; i++) setw(4, i, int'($urandom_range(0, 255)));
        for (int i = 0; i < NI; i++) setw(12, i, int'($urandom_range(0, 255)));
        compute_expected();
        for (int n = 0; n < NH; n++) got[n] = -1;

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Run 1: stall at neuron 3, stray start while busy
        pulse_start();
        wait_for(0, 3*NI + 500, 4000, "reach_neuron3");
        hif.hid_ready = 1'b0;
        wait_for(1, 0, 1000, "valid_neuron3");
        repeat (10) @(posedge clk);
        #1;
        chk(hif.hid_valid == 1, "stall_valid", int'(hif.hid_valid), 1);
        chk(hif.hid_idx == 5'd3, "stall_idx", int'(hif.hid_idx), 3);
        chk(hif.hid_val == 8'd30, "stall_val", int'(hif.hid_val), 30);
        hif.hid_ready = 1'b1;
        wait_for(0, 6*NI + 50, 4000, "reach_neuron6");
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_for(2, 0, 30000, "run1_done");
        check_literals();

        // Run 2: abort during neuron 10, then a clean full-latency run
        for (int n = 0; n < NH; n++) got[n] = -1;
        pulse_start();
        wait_for(0, 10*NI + 300, 12000, "reach_neuron10");
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_zero_outputs("abort");
        repeat (3) @(posedge clk);
        #1;
        for (int n = 0; n < NH; n++) got[n] = -1;
        full_lat = 1;
        pulse_start();
        wait_for(2, 0, 30000, "run2_done");
        check_literals();
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
